// File: rtl/self_attention_pkg.sv
// -----------------------------------------------------------------------------
// self_attention_pkg
// Shared types and defaults for the self-attention head sequencer.
//   seq_state_e      : sequencer FSM states
//   DEF_INNER_BLOCKS : operand beats per output tile (inner dim / block size)
//   DEF_ACC_TIMEOUT  : maximum cycles spent waiting for accumulation done
//   sat_inc32        : saturating 32-bit increment used by the optional
//                      performance counters (SA_SEQ_PERF_CNT_EN)
// -----------------------------------------------------------------------------
package self_attention_pkg;

  localparam int INNER_DIMENSION_QN_KNT = 16;
  localparam int BLOCK_SIZE             = 4;
  localparam int DEF_INNER_BLOCKS       = INNER_DIMENSION_QN_KNT / BLOCK_SIZE;
  localparam int DEF_ACC_TIMEOUT        = 1024;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR      = 3'd1,
    FEED     = 3'd2,
    WAIT_ACC = 3'd3,
    DRAIN    = 3'd4,
    FIN      = 3'd5
  } seq_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/sa_seq_beat_counter.sv
// -----------------------------------------------------------------------------
// sa_seq_beat_counter
// Loadable up-counter with a terminal-count flag. The flag is raised while the
// count equals TERMINAL-1, i.e. the next increment completes the run, so the
// owner can take its transition in the same cycle as the final event.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load load_value (has priority over inc)
//   load_value  : value loaded on load
//   inc         : increment by one
//   last        : count == TERMINAL-1
// -----------------------------------------------------------------------------
module sa_seq_beat_counter #(
  parameter int WIDTH    = 3,
  parameter int TERMINAL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  output logic             last
);

  localparam logic [WIDTH-1:0] LAST_VALUE = WIDTH'(TERMINAL - 1);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (inc) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign last = (count_reg == LAST_VALUE);

endmodule

// File: rtl/self_attention_seq_ctrl.sv
// -----------------------------------------------------------------------------
// self_attention_seq_ctrl
// Sequencer for the Qn x Kn^T matmul wrapper and the following 4-bit shift
// stage. Per tile: clear accumulators (CLR), stream INNER_BLOCKS operand beats
// (FEED), wait for accumulation done (WAIT_ACC), hand the tile to the shifter
// (DRAIN). After the latched number of tiles, FIN produces the done pulse.
// Optional feature macro: SA_SEQ_PERF_CNT_EN (adds perf_stall_cycles and
// perf_busy_cycles saturating counters).
// Ports:
//   start/abort/cfg_num_tiles : run control; cfg latched on accepted start
//   op_valid/op_ready         : operand beat handshake
//   mm_en/mm_reset_acc        : enable / accumulator clear toward the matmul
//   mm_acc_done/mm_sys_finish : matmul status (sys_finish only monitored)
//   out_valid/out_ready       : tile handshake toward the shifter
//   tile_idx, busy, done, err : status; done is registered, so it appears in
//                               the cycle after FIN; err is sticky
// -----------------------------------------------------------------------------
module self_attention_seq_ctrl
  import self_attention_pkg::*;
#(
  parameter int INNER_BLOCKS = DEF_INNER_BLOCKS,
  parameter int TILE_CNT_W   = 8,
  parameter int ACC_TIMEOUT  = DEF_ACC_TIMEOUT,
  parameter int BEAT_CNT_W   = $clog2(INNER_BLOCKS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TILE_CNT_W-1:0] cfg_num_tiles,
  input  logic                  op_valid,
  output logic                  op_ready,
  output logic                  mm_en,
  output logic                  mm_reset_acc,
  input  logic                  mm_acc_done,
  input  logic                  mm_sys_finish,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TILE_CNT_W-1:0] tile_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef SA_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_busy_cycles
`endif
);

  localparam int TO_CNT_W = $clog2(ACC_TIMEOUT + 1);

  seq_state_e state_reg, state_next;

  logic [TILE_CNT_W-1:0] num_tiles_reg;
  logic [TILE_CNT_W-1:0] tile_idx_reg;
  logic [TILE_CNT_W-1:0] tile_inc;
  logic                  err_reg;
  logic                  done_reg;

  logic start_accept;
  logic feed_beat;
  logic drain_hs;
  logic beat_last;
  logic to_last;
  logic err_event;

  assign start_accept = (state_reg == IDLE) && start && !abort;
  assign feed_beat    = (state_reg == FEED) && op_valid;
  assign drain_hs     = (state_reg == DRAIN) && out_ready;
  assign tile_inc     = tile_idx_reg + TILE_CNT_W'(1);

  // Protocol violations and the accumulation timeout; none of them alter flow
  // except the timeout, which is handled in the next-state logic.
  assign err_event = (((state_reg == FEED) || (state_reg == CLR)) && mm_acc_done)
                   || ((state_reg == IDLE) && mm_sys_finish)
                   || ((state_reg == WAIT_ACC) && !mm_acc_done && to_last);

  sa_seq_beat_counter #(
    .WIDTH    (BEAT_CNT_W),
    .TERMINAL (INNER_BLOCKS)
  ) u_beat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (state_reg == CLR),
    .load_value ('0),
    .inc        (feed_beat),
    .last       (beat_last)
  );

  // Held at zero outside WAIT_ACC, so every wait starts a fresh budget.
  sa_seq_beat_counter #(
    .WIDTH    (TO_CNT_W),
    .TERMINAL (ACC_TIMEOUT)
  ) u_timeout_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (state_reg != WAIT_ACC),
    .load_value ('0),
    .inc        (state_reg == WAIT_ACC),
    .last       (to_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (cfg_num_tiles == '0) ? FIN : CLR;
        end
      end
      CLR:  state_next = FEED;
      FEED: begin
        if (op_valid && beat_last) begin
          state_next = WAIT_ACC;
        end
      end
      WAIT_ACC: begin
        // acc_done wins over a simultaneous timeout; out_ready is not looked at.
        if (mm_acc_done) begin
          state_next = DRAIN;
        end else if (to_last) begin
          state_next = FIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          state_next = (tile_inc == num_tiles_reg) ? FIN : CLR;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
    end
  end

  // Output decode
  always_comb begin
    op_ready     = 1'b0;
    mm_en        = 1'b0;
    mm_reset_acc = 1'b0;
    out_valid    = 1'b0;
    busy         = (state_reg != IDLE);
    case (state_reg)
      CLR:      mm_reset_acc = 1'b1;
      FEED: begin
        op_ready = op_valid;
        mm_en    = op_valid;
      end
      WAIT_ACC: mm_en     = 1'b1;
      DRAIN:    out_valid = 1'b1;
      default:  ;
    endcase
  end

  // Run bookkeeping: latched tile count, tile index, sticky error, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_tiles_reg <= '0;
      tile_idx_reg  <= '0;
      err_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else if (abort) begin
      // Error state is deliberately preserved across an abort.
      tile_idx_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= (state_reg == FIN);
      if (start_accept) begin
        num_tiles_reg <= cfg_num_tiles;
        tile_idx_reg  <= '0;
      end else if (drain_hs) begin
        tile_idx_reg <= tile_inc;
      end
      if (err_event) begin
        err_reg <= 1'b1;
      end else if (start_accept) begin
        err_reg <= 1'b0;
      end
    end
  end

  assign tile_idx = tile_idx_reg;
  assign done     = done_reg;
  assign err      = err_reg;

`ifdef SA_SEQ_PERF_CNT_EN
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_busy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_reg <= '0;
      perf_busy_reg  <= '0;
    end else if (start_accept) begin
      perf_stall_reg <= '0;
      perf_busy_reg  <= '0;
    end else begin
      if (((state_reg == FEED) && !op_valid) || ((state_reg == DRAIN) && !out_ready)) begin
        perf_stall_reg <= sat_inc32(perf_stall_reg);
      end
      if (state_reg != IDLE) begin
        perf_busy_reg <= sat_inc32(perf_busy_reg);
      end
    end
  end

  assign perf_stall_cycles = perf_stall_reg;
  assign perf_busy_cycles  = perf_busy_reg;
`endif

endmodule
